// File: rtl/adpcm_mc_if.sv
// Request/response bundle between the sample DMA (master) and the adpcm_mc codec (slave).
interface adpcm_mc_if #(
    parameter int CH_W = 2
);
    logic            enable;
    logic            sel_rx;
    logic [CH_W-1:0] ch;
    logic            clr;
    logic            req;
    logic [15:0]     rx_pcm;
    logic [3:0]      rx_adpcm;
    logic [3:0]      tx_adpcm;
    logic [15:0]     tx_pcm;
    logic            ack;
    logic            busy;
    logic            ovr;
    logic            err;

    modport master (
        output enable, sel_rx, ch, clr, req, rx_pcm, rx_adpcm,
        input  tx_adpcm, tx_pcm, ack, busy, ovr, err
    );
    modport slave (
        input  enable, sel_rx, ch, clr, req, rx_pcm, rx_adpcm,
        output tx_adpcm, tx_pcm, ack, busy, ovr, err
    );
endinterface

// File: rtl/adpcm_mc.sv
// Multi-channel IMA ADPCM codec: one bit-serial encode/decode datapath shared by NCH channels,
// each keeping its own predictor and step index.
module adpcm_mc #(
    parameter int NCH        = 4,
    parameter int CH_W       = 2,
    parameter int PCM_W      = 16,
    parameter int INIT_INDEX = 0
) (
    input  logic      clk,
    input  logic      rstn,
    adpcm_mc_if.slave bus
);
    if (PCM_W != 16) begin : g_pcm_w_check
        $error("adpcm_mc: PCM_W must be 16");
    end
    if (NCH < 1 || NCH > 16 || (1 << CH_W) < NCH) begin : g_nch_check
        $error("adpcm_mc: NCH must be 1..16 and fit in CH_W bits");
    end
    if (INIT_INDEX < 0 || INIT_INDEX > 88) begin : g_init_check
        $error("adpcm_mc: INIT_INDEX must be 0..88");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_B2, S_B1, S_B0, S_UPD, S_ACK} state_t;

    localparam int STEP_TBL [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
        253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
        1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
        3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487,
        12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    state_t             state_q, state_d;
    logic               armed_q, armed_d, req_dly_q, req_dly_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               sel_q, sel_d, oor_q, oor_d;
    logic [15:0]        pcm_in_q, pcm_in_d;
    logic signed [15:0] wpred_q, wpred_d;
    logic [6:0]         widx_q, widx_d;
    logic [15:0]        step_q, step_d;
    logic [16:0]        mag_q, mag_d;
    logic [3:0]         code_q, code_d;
    logic [3:0]         tx_adpcm_q, tx_adpcm_d;
    logic [15:0]        tx_pcm_q, tx_pcm_d;
    logic               ovr_q, ovr_d, err_q, err_d;
    logic signed [15:0] pred_q [NCH];
    logic signed [15:0] pred_d [NCH];
    logic [6:0]         idx_q [NCH];
    logic [6:0]         idx_d [NCH];

    logic               req_tgl;
    logic [1:0]         bpos;
    logic signed [16:0] diff;
    logic [16:0]        trial, dq;
    logic signed [17:0] sum;
    logic signed [15:0] newp;
    logic signed [8:0]  nidx;

    always_comb begin
        state_d    = state_q;    ch_d     = ch_q;     sel_d    = sel_q;
        oor_d      = oor_q;      pcm_in_d = pcm_in_q; wpred_d  = wpred_q;
        widx_d     = widx_q;     step_d   = step_q;   mag_d    = mag_q;
        code_d     = code_q;     tx_pcm_d = tx_pcm_q; tx_adpcm_d = tx_adpcm_q;
        ovr_d      = ovr_q;      err_d    = err_q;
        pred_d     = pred_q;     idx_d    = idx_q;
        req_dly_d  = bus.req;    armed_d  = 1'b1;
        req_tgl    = armed_q & (bus.req ^ req_dly_q);
        bpos = 2'd0; diff = '0; trial = '0; dq = '0; sum = '0; newp = '0; nidx = '0;

        if (req_tgl && state_q != S_IDLE) ovr_d = 1'b1;

        case (state_q)
            S_IDLE: if (req_tgl && bus.enable) begin
                ch_d     = bus.ch;
                sel_d    = bus.sel_rx;
                pcm_in_d = bus.rx_pcm;
                code_d   = bus.rx_adpcm;
                oor_d    = int'(bus.ch) >= NCH;
                if (oor_d) err_d = 1'b1;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                wpred_d = '0;
                widx_d  = 7'(INIT_INDEX);
                if (!oor_q) begin
                    wpred_d = pred_q[ch_q];
                    widx_d  = idx_q[ch_q];
                end
                step_d = 16'(STEP_TBL[widx_d]);
                diff   = $signed({pcm_in_q[15], pcm_in_q}) - $signed({wpred_d[15], wpred_d});
                if (!sel_q) begin
                    code_d = {diff[16], 3'b000};
                    mag_d  = diff[16] ? 17'(-diff) : 17'(diff);
                end
                state_d = S_B2;
            end
            S_B2, S_B1, S_B0: begin
                // MSB-first successive approximation against step, step/2, step/4
                bpos  = (state_q == S_B2) ? 2'd2 : (state_q == S_B1) ? 2'd1 : 2'd0;
                trial = {1'b0, step_q} >> (2'd2 - bpos);
                if (!sel_q && mag_q >= trial) begin
                    mag_d        = mag_q - trial;
                    code_d[bpos] = 1'b1;
                end
                state_d = (bpos == 2'd0) ? S_UPD : state_t'(state_q + 3'd1);
            end
            S_UPD: begin
                dq = {4'b0, step_q[15:3]};
                if (code_q[2]) dq = dq + {1'b0, step_q};
                if (code_q[1]) dq = dq + {2'b0, step_q[15:1]};
                if (code_q[0]) dq = dq + {3'b0, step_q[15:2]};
                sum = code_q[3] ? $signed({{2{wpred_q[15]}}, wpred_q}) - $signed({1'b0, dq})
                                : $signed({{2{wpred_q[15]}}, wpred_q}) + $signed({1'b0, dq});
                if (sum > 18'sd32767)       newp = 16'sh7fff;
                else if (sum < -18'sd32768) newp = 16'sh8000;
                else                        newp = sum[15:0];
                nidx = $signed({2'b00, widx_q}) +
                       (code_q[2] ? $signed({6'b0, code_q[1:0], 1'b0}) + 9'sd2 : -9'sd1);
                if (!oor_q) begin
                    pred_d[ch_q] = newp;
                    idx_d[ch_q]  = (nidx < 0) ? 7'd0 : (nidx > 9'sd88) ? 7'd88 : nidx[6:0];
                    tx_pcm_d     = newp;
                    if (!sel_q) tx_adpcm_d = code_q;
                end
                state_d = S_ACK;
            end
            default: state_d = S_IDLE;
        endcase

        // Losing enable abandons the request before any channel state is written.
        if (!bus.enable && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            pred_d     = pred_q;
            idx_d      = idx_q;
            tx_pcm_d   = tx_pcm_q;
            tx_adpcm_d = tx_adpcm_q;
        end
        if (bus.clr) begin
            state_d = S_IDLE;
            ovr_d   = 1'b0;
            err_d   = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                pred_d[i] = '0;
                idx_d[i]  = 7'(INIT_INDEX);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE; armed_q  <= 1'b0; req_dly_q <= 1'b0;
            ch_q     <= '0;     sel_q    <= 1'b0; oor_q     <= 1'b0;
            pcm_in_q <= '0;     wpred_q  <= '0;   widx_q    <= '0;
            step_q   <= '0;     mag_q    <= '0;   code_q    <= '0;
            tx_pcm_q <= '0;     tx_adpcm_q <= '0;
            ovr_q    <= 1'b0;   err_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                pred_q[i] <= '0;
                idx_q[i]  <= 7'(INIT_INDEX);
            end
        end else begin
            state_q  <= state_d;  armed_q  <= armed_d;  req_dly_q <= req_dly_d;
            ch_q     <= ch_d;     sel_q    <= sel_d;    oor_q     <= oor_d;
            pcm_in_q <= pcm_in_d; wpred_q  <= wpred_d;  widx_q    <= widx_d;
            step_q   <= step_d;   mag_q    <= mag_d;    code_q    <= code_d;
            tx_pcm_q <= tx_pcm_d; tx_adpcm_q <= tx_adpcm_d;
            ovr_q    <= ovr_d;    err_q    <= err_d;
            pred_q   <= pred_d;   idx_q    <= idx_d;
        end
    end

    assign bus.tx_adpcm = tx_adpcm_q;
    assign bus.tx_pcm   = tx_pcm_q;
    assign bus.ack      = (state_q == S_ACK);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.ovr      = ovr_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_adpcm_mc.sv
// Directed bench for adpcm_mc: an IMA reference model fills a scoreboard that is checked at each ack.
module tb_adpcm_mc;
    localparam int NCH = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    adpcm_mc_if #(.CH_W(2)) bus ();
    adpcm_mc #(.NCH(NCH), .CH_W(2), .PCM_W(16), .INIT_INDEX(0)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    typedef struct { logic [3:0] code; logic [15:0] pcm; } exp_t;
    exp_t exp_q [$];

    int vectors = 0;
    int miscompares = 0;
    int m_pred [NCH];
    int m_idx  [NCH];
    int m_txa, m_txp;
    int step_tab [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
        253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
        1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
        3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487,
        12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pred[i] = 0;
            m_idx[i]  = 0;
        end
    endtask

    // Textbook IMA step, pushing the expected tx_adpcm/tx_pcm seen at ack.
    task automatic model_req(input bit dec, input int c, input int pcm, input int cin);
        int step, diff, code, vp, p, ix;
        exp_t e;
        if (c < NCH) begin
            step = step_tab[m_idx[c]];
            p    = m_pred[c];
            if (dec) code = cin;
            else begin
                diff = pcm - p;
                code = 0;
                if (diff < 0) begin code = 8; diff = -diff; end
                if (diff >= step)     begin code += 4; diff -= step;     end
                if (diff >= step / 2) begin code += 2; diff -= step / 2; end
                if (diff >= step / 4) begin code += 1; end
                m_txa = code;
            end
            vp = step / 8;
            if ((code & 4) != 0) vp += step;
            if ((code & 2) != 0) vp += step / 2;
            if ((code & 1) != 0) vp += step / 4;
            p = ((code & 8) != 0) ? p - vp : p + vp;
            if (p > 32767)  p = 32767;
            if (p < -32768) p = -32768;
            ix = m_idx[c] + (((code & 4) != 0) ? 2 * ((code & 3) + 1) : -1);
            if (ix < 0)  ix = 0;
            if (ix > 88) ix = 88;
            m_pred[c] = p;
            m_idx[c]  = ix;
            m_txp     = p;
        end
        e.code = 4'(m_txa);
        e.pcm  = 16'(m_txp);
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: ack observed with no expected result queued", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".code"}, 32'(bus.tx_adpcm), 32'(e.code));
            chk({tag, ".pcm"},  32'(bus.tx_pcm),   32'(e.pcm));
        end
    endtask

    task automatic drive(input bit dec, input int c, input int pcm, input int cin);
        @(negedge clk);
        bus.sel_rx   = dec;
        bus.ch       = 2'(c);
        bus.rx_pcm   = 16'(pcm);
        bus.rx_adpcm = 4'(cin);
        bus.req      = ~bus.req;
    endtask

    // Posedges from the sampling edge (inclusive) until ack; inputs are scrambled once latched.
    task automatic wait_ack(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                bus.rx_pcm   = 16'($urandom);
                bus.rx_adpcm = 4'($urandom);
                bus.sel_rx   = ~bus.sel_rx;
                bus.ch       = ~bus.ch;
            end
            if (bus.ack) break;
        end
    endtask

    task automatic count_acks(input int cycles, output int k);
        k = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (bus.ack) k++;
        end
    endtask

    task automatic do_req(input bit dec, input int c, input int pcm, input int cin);
        int n;
        drive(dec, c, pcm, cin);
        model_req(dec, c, pcm, cin);
        wait_ack(n);
        chk("latency", n, 6);
        pop_check("req");
        @(posedge clk); #1;
        chk("ack_pulse", 32'(bus.ack), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".tx_pcm"},   32'(bus.tx_pcm),   0);
        chk({tag, ".tx_adpcm"}, 32'(bus.tx_adpcm), 0);
        chk({tag, ".ack"},      32'(bus.ack),      0);
        chk({tag, ".busy"},     32'(bus.busy),     0);
        chk({tag, ".ovr"},      32'(bus.ovr),      0);
        chk({tag, ".err"},      32'(bus.err),      0);
    endtask

    initial begin
        int k, prev;
        bus.enable = 1'b1; bus.sel_rx = 1'b0; bus.ch = '0; bus.clr = 1'b0;
        bus.req = 1'b0; bus.rx_pcm = '0; bus.rx_adpcm = '0;
        model_reset();
        m_txa = 0; m_txp = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rstn = 1'b1;

        do_req(0, 0, 100, 0);
        chk("first.code", 32'(bus.tx_adpcm), 7);
        chk("first.pcm",  32'(bus.tx_pcm),   11);
        do_req(0, 1, 100, 0);
        do_req(0, 0, 100, 0);
        chk("iso.pcm", 32'(bus.tx_pcm), 41);
        do_req(0, 2, -100, 0);
        chk("neg.code", 32'(bus.tx_adpcm), 15);
        chk("neg.pcm",  32'(bus.tx_pcm),   32'h0000fff5);

        @(negedge clk); bus.clr = 1'b1;
        @(negedge clk); bus.clr = 1'b0;
        model_reset();
        do_req(1, 0, 0, 7);
        chk("dec7.pcm", 32'(bus.tx_pcm), 11);

        repeat (10) do_req(1, 1, 0, 0);
        chk("dec0.pcm", 32'(bus.tx_pcm), 0);
        do_req(1, 1, 0, 7);
        chk("dec_after_clamp.pcm", 32'(bus.tx_pcm), 11);

        prev = -32768;
        for (int i = 0; i < 40; i++) begin
            do_req(0, 2, 32767, 0);
            chk("sat.mono", ($signed(bus.tx_pcm) >= prev) ? 1 : 0, 1);
            prev = $signed(bus.tx_pcm);
        end
        chk("sat.end", 32'(bus.tx_pcm), 32767);
        do_req(0, 2, 0, 0);

        drive(0, 0, 500, 0);
        model_req(0, 0, 500, 0);
        @(negedge clk); @(negedge clk);
        bus.req = ~bus.req;
        k = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (bus.ack) begin
                k++;
                if (k == 1) pop_check("ovr_req");
            end
        end
        chk("ovr.acks", k, 1);
        chk("ovr.flag", 32'(bus.ovr), 1);

        do_req(0, 3, 1234, 0);
        chk("err.flag", 32'(bus.err), 1);
        do_req(0, 0, -500, 0);

        drive(0, 1, 2000, 0);
        repeat (3) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk); bus.clr = 1'b0;
        count_acks(10, k);
        chk("clr.acks", k, 0);
        chk("clr.ovr",  32'(bus.ovr),  0);
        chk("clr.err",  32'(bus.err),  0);
        chk("clr.busy", 32'(bus.busy), 0);
        model_reset();
        for (int c = 0; c < NCH; c++) begin
            do_req(1, c, 0, 7);
            chk("clr_dec7.pcm", 32'(bus.tx_pcm), 11);
        end

        drive(0, 1, 3000, 0);
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk); bus.enable = 1'b1;
        count_acks(10, k);
        chk("en.acks", k, 0);
        chk("en.busy", 32'(bus.busy), 0);
        do_req(0, 1, 3000, 0);

        drive(0, 2, 4000, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk); rstn = 1'b1;
        model_reset();
        m_txa = 0; m_txp = 0;
        exp_q.delete();
        do_req(0, 0, 100, 0);
        chk("post_rst.pcm", 32'(bus.tx_pcm), 11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
